// File: rtl/patch_bank_mem.sv
// Banked patch store: streamed writes at an internal pointer, one pipelined 2-cycle random read port.
// Optional per-element even parity in the spare macro MSBs when PATCH_PARITY_EN is defined.
module patch_bank_mem #(
  parameter int DATA_WIDTH  = 11,
  parameter int PATCH_SIZE  = 5,
  parameter int NUM_BANKS   = 2,
  parameter int BANK_DEPTH  = 256,
  parameter int MACRO_WIDTH = 32,
  parameter int ADDR_WIDTH  = $clog2(NUM_BANKS*BANK_DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [PATCH_SIZE*DATA_WIDTH-1:0] wr_patch,
  output logic [ADDR_WIDTH:0]              wr_count,
  output logic                             full,
  input  logic                             rd_req,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic                             rd_valid,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0] rd_patch
`ifdef PATCH_PARITY_EN
  ,
  output logic [PATCH_SIZE-1:0]            rd_parity_err
`endif
);

  localparam int PW     = PATCH_SIZE*DATA_WIDTH;
  localparam int MPB    = (PW + MACRO_WIDTH - 1) / MACRO_WIDTH;
  localparam int BW     = MPB*MACRO_WIDTH;
  localparam int ROW_W  = $clog2(BANK_DEPTH);
  localparam int BANK_W = ADDR_WIDTH - ROW_W;
  localparam int CW     = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] TOTAL_C = CW'(NUM_BANKS*BANK_DEPTH);

  function automatic logic [PATCH_SIZE-1:0] elem_parity(input logic [PW-1:0] p);
    logic [PATCH_SIZE-1:0] par;
    for (int e = 0; e < PATCH_SIZE; e++) begin
      par[e] = ^p[e*DATA_WIDTH +: DATA_WIDTH];
    end
    return par;
  endfunction

  function automatic logic [BW-1:0] pack_word(input logic [PW-1:0] p);
    logic [BW-1:0] w;
    w = '0;
    w[PW-1:0] = p;
`ifdef PATCH_PARITY_EN
    w[PW +: PATCH_SIZE] = elem_parity(p);
`endif
    return w;
  endfunction

  logic [CW-1:0]         wr_count_q, wr_count_d;
  logic                  full_q, full_d;
  logic                  wr_ready_q, wr_ready_d;
  logic                  wr_fire_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s;
  logic [BANK_W-1:0]     wr_bank_s, rd_bank_s;
  logic [ROW_W-1:0]      wr_row_s, rd_row_s;
  logic [BW-1:0]         wr_word_s;
  logic                  rd_in_range_s, rd_access_s, rd_hit_s;
  logic [NUM_BANKS-1:0]  csb0_s, web0_s, csb1_s;

  logic                  v1_q, v1_d, oor1_q, oor1_d, hit1_q, hit1_d;
  logic [BANK_W-1:0]     bank1_q, bank1_d;
  logic [PW-1:0]         byp1_q, byp1_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [PW-1:0]         rd_patch_q, rd_patch_d;
  logic [BW-1:0]         sel_word_s;
  logic [MPB-1:0][MACRO_WIDTH-1:0] rd_word_s [NUM_BANKS];

  // Write pointer, occupancy and macro port selects; nothing is selected while rst_n is low.
  always_comb begin
    wr_addr_s     = wr_count_q[ADDR_WIDTH-1:0];
    wr_bank_s     = wr_addr_s[ADDR_WIDTH-1:ROW_W];
    wr_row_s      = wr_addr_s[ROW_W-1:0];
    wr_word_s     = pack_word(wr_patch);
    wr_fire_s     = rst_n && wr_valid && wr_ready_q && !clear;
    rd_bank_s     = rd_addr[ADDR_WIDTH-1:ROW_W];
    rd_row_s      = rd_addr[ROW_W-1:0];
    rd_in_range_s = ({1'b0, rd_addr} < TOTAL_C);
    rd_access_s   = rst_n && rd_req && rd_in_range_s;
    rd_hit_s      = rd_req && wr_fire_s && (rd_addr == wr_addr_s);
    if (clear) begin
      wr_count_d = '0;
    end else if (wr_fire_s) begin
      wr_count_d = wr_count_q + CW'(1);
    end else begin
      wr_count_d = wr_count_q;
    end
    full_d     = (wr_count_d == TOTAL_C);
    wr_ready_d = !full_d;
    for (int b = 0; b < NUM_BANKS; b++) begin
      csb0_s[b] = !(wr_fire_s && (wr_bank_s == BANK_W'(b)));
      web0_s[b] = csb0_s[b];
      csb1_s[b] = !(rd_access_s && (rd_bank_s == BANK_W'(b)));
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    for (genvar m = 0; m < MPB; m++) begin : g_mac
      logic [MACRO_WIDTH-1:0] mem_q [BANK_DEPTH];
      logic [MACRO_WIDTH-1:0] dout_q;
      // Behavioural 1rw1r macro: port 0 writes, port 1 reads with one cycle latency.
      always_ff @(posedge clk) begin
        if (!csb0_s[b] && !web0_s[b]) begin
          mem_q[wr_row_s] <= wr_word_s[m*MACRO_WIDTH +: MACRO_WIDTH];
        end
        if (!csb1_s[b]) begin
          dout_q <= mem_q[rd_row_s];
        end
      end
      assign rd_word_s[b][m] = dout_q;
    end
  end

  // Read pipeline: the delayed bank index, not the live address, steers the output mux.
  always_comb begin
    v1_d       = rd_req;
    bank1_d    = rd_bank_s;
    oor1_d     = !rd_in_range_s;
    hit1_d     = rd_hit_s;
    byp1_d     = rd_hit_s ? wr_patch : byp1_q;
    sel_word_s = rd_word_s[bank1_q];
    rd_valid_d = v1_q;
    if (!v1_q) begin
      rd_patch_d = rd_patch_q;
    end else if (hit1_q) begin
      rd_patch_d = byp1_q;
    end else if (oor1_q) begin
      rd_patch_d = '0;
    end else begin
      rd_patch_d = sel_word_s[PW-1:0];
    end
  end

`ifdef PATCH_PARITY_EN
  logic [PATCH_SIZE-1:0] perr_q, perr_d;
  logic                  unused_pad_s;
  assign unused_pad_s = ^sel_word_s[BW-1:PW];

  // Parity recheck of macro data; bypassed and out-of-range reads never flag.
  always_comb begin
    if (!v1_q) begin
      perr_d = perr_q;
    end else if (hit1_q || oor1_q) begin
      perr_d = '0;
    end else begin
      perr_d = elem_parity(sel_word_s[PW-1:0]) ^ sel_word_s[PW +: PATCH_SIZE];
    end
  end

  // Parity error flags register alongside rd_patch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_q <= '0;
    end else begin
      perr_q <= perr_d;
    end
  end
  assign rd_parity_err = perr_q;
`else
  logic unused_pad_s;
  assign unused_pad_s = ^sel_word_s[BW-1:PW];
`endif

  // Control and pipeline state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count_q <= '0;
      full_q     <= 1'b0;
      wr_ready_q <= 1'b1;
      v1_q       <= 1'b0;
      bank1_q    <= '0;
      oor1_q     <= 1'b0;
      hit1_q     <= 1'b0;
      byp1_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_patch_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
      full_q     <= full_d;
      wr_ready_q <= wr_ready_d;
      v1_q       <= v1_d;
      bank1_q    <= bank1_d;
      oor1_q     <= oor1_d;
      hit1_q     <= hit1_d;
      byp1_q     <= byp1_d;
      rd_valid_q <= rd_valid_d;
      rd_patch_q <= rd_patch_d;
    end
  end

  assign wr_count = wr_count_q;
  assign full     = full_q;
  assign wr_ready = wr_ready_q;
  assign rd_valid = rd_valid_q;
  assign rd_patch = rd_patch_q;

endmodule

// File: tb/tb_patch_bank_mem.sv
// Directed self-checking bench for patch_bank_mem (default 2x256 banks, 5x11-bit patches).
module tb_patch_bank_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [54:0] wr_patch = '0;
  logic [9:0]  wr_count;
  logic        full;
  logic        rd_req = 1'b0;
  logic [8:0]  rd_addr = '0;
  logic        rd_valid;
  logic [54:0] rd_patch;
`ifdef PATCH_PARITY_EN
  logic [4:0]  rd_parity_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  patch_bank_mem dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_patch(wr_patch),
    .wr_count(wr_count), .full(full),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_patch(rd_patch)
`ifdef PATCH_PARITY_EN
    , .rd_parity_err(rd_parity_err)
`endif
  );

  typedef struct {
    logic        req;
    logic [8:0]  addr;
    logic        exp_valid;
    logic [54:0] exp_patch;
  } rd_vec_t;

  rd_vec_t vec [12];

  function automatic logic [54:0] mk_patch(input int v);
    logic [54:0] p;
    for (int e = 0; e < 5; e++) p[e*11 +: 11] = 11'(v);
    return p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_patch(input logic [54:0] p);
    wr_valid = 1'b1;
    wr_patch = p;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic read_patch(input logic [8:0] a, output logic v, output logic [54:0] p);
    rd_req  = 1'b1;
    rd_addr = a;
    tick();
    rd_req = 1'b0;
    tick();
    v = rd_valid;
    p = rd_patch;
  endtask

  logic        v;
  logic [54:0] p;

  initial begin
    vec[0]  = '{1'b1, 9'd5,   1'b0, 55'd0};
    vec[1]  = '{1'b1, 9'd255, 1'b1, mk_patch(5)};
    vec[2]  = '{1'b1, 9'd256, 1'b1, mk_patch(255)};
    vec[3]  = '{1'b1, 9'd511, 1'b1, mk_patch(256)};
    vec[4]  = '{1'b0, 9'd0,   1'b1, mk_patch(511)};
    vec[5]  = '{1'b0, 9'd0,   1'b0, mk_patch(511)};
    vec[6]  = '{1'b1, 9'd0,   1'b0, mk_patch(511)};
    vec[7]  = '{1'b0, 9'd0,   1'b1, mk_patch(0)};
    vec[8]  = '{1'b1, 9'd300, 1'b0, mk_patch(0)};
    vec[9]  = '{1'b1, 9'd301, 1'b1, mk_patch(300)};
    vec[10] = '{1'b0, 9'd0,   1'b1, mk_patch(301)};
    vec[11] = '{1'b0, 9'd0,   1'b0, mk_patch(301)};

    #12;
    check("reset_wr_count", 64'(wr_count), 64'd0);
    check("reset_full", 64'(full), 64'd0);
    check("reset_wr_ready", 64'(wr_ready), 64'd1);
    check("reset_rd_valid", 64'(rd_valid), 64'd0);
    check("reset_rd_patch", 64'(rd_patch), 64'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 512; i++) begin
      write_patch(mk_patch(i));
      if (i == 0)   check("count_after_1", 64'(wr_count), 64'd1);
      if (i == 255) check("count_after_256", 64'(wr_count), 64'd256);
      if (i == 510) check("not_full_511", 64'(full), 64'd0);
    end
    check("count_512", 64'(wr_count), 64'd512);
    check("full_512", 64'(full), 64'd1);
    check("ready_512", 64'(wr_ready), 64'd0);
    write_patch(mk_patch(999));
    check("count_after_513th", 64'(wr_count), 64'd512);

    for (int i = 0; i < 12; i++) begin
      rd_req  = vec[i].req;
      rd_addr = vec[i].addr;
      tick();
      check($sformatf("vec%0d_valid", i), 64'(rd_valid), 64'(vec[i].exp_valid));
      check($sformatf("vec%0d_patch", i), 64'(rd_patch), 64'(vec[i].exp_patch));
    end
    rd_req = 1'b0;

    clear    = 1'b1;
    wr_valid = 1'b1;
    wr_patch = mk_patch(42);
    tick();
    clear    = 1'b0;
    wr_valid = 1'b0;
    check("clear_count", 64'(wr_count), 64'd0);
    check("clear_full", 64'(full), 64'd0);
    check("clear_ready", 64'(wr_ready), 64'd1);

    for (int i = 0; i < 10; i++) write_patch(mk_patch(1000 + i));
    wr_valid = 1'b1;
    wr_patch = 55'h1234;
    rd_req   = 1'b1;
    rd_addr  = 9'd10;
    tick();
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    check("collide_n1_valid", 64'(rd_valid), 64'd0);
    tick();
    check("collide_valid", 64'(rd_valid), 64'd1);
    check("collide_patch", 64'(rd_patch), 64'h1234);
    check("collide_count", 64'(wr_count), 64'd11);
    read_patch(9'd10, v, p);
    check("addr10_after_collide", 64'(p), 64'h1234);

    for (int i = 11; i < 300; i++) write_patch(mk_patch(1000 + i));
    check("count_300", 64'(wr_count), 64'd300);
    clear    = 1'b1;
    wr_valid = 1'b1;
    wr_patch = mk_patch(77);
    tick();
    clear    = 1'b0;
    wr_valid = 1'b0;
    check("clear2_count", 64'(wr_count), 64'd0);
    write_patch(mk_patch(1500));
    check("count_after_clear_write", 64'(wr_count), 64'd1);
    read_patch(9'd0, v, p);
    check("addr0_new", 64'(p), 64'(mk_patch(1500)));
    read_patch(9'd299, v, p);
    check("addr299_old", 64'(p), 64'(mk_patch(1299)));
    read_patch(9'd1, v, p);
    check("addr1_old", 64'(p), 64'(mk_patch(1001)));
    read_patch(9'd300, v, p);
    check("addr300_untouched", 64'(p), 64'(mk_patch(300)));
    check("addr300_valid", 64'(v), 64'd1);

    rd_req  = 1'b1;
    rd_addr = 9'd5;
    tick();
    rd_req = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("midrst_valid", 64'(rd_valid), 64'd0);
    check("midrst_patch", 64'(rd_patch), 64'd0);
    check("midrst_count", 64'(wr_count), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("postrst_valid%0d", i), 64'(rd_valid), 64'd0);
      check($sformatf("postrst_patch%0d", i), 64'(rd_patch), 64'd0);
    end

`ifdef PATCH_PARITY_EN
    read_patch(9'd259, v, p);
    check("parity_clean", 64'(rd_parity_err), 64'd0);
    dut.g_bank[1].g_mac[0].mem_q[3][4] = ~dut.g_bank[1].g_mac[0].mem_q[3][4];
    read_patch(9'd259, v, p);
    check("parity_flag_elem0", 64'(rd_parity_err), 64'd1);
    read_patch(9'd258, v, p);
    check("parity_other_row", 64'(rd_parity_err), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/patch_bank_mem.md
Name: patch_bank_mem

Overview:
Parametrised successor of the query patch store. Holds streamed query patches in NUM_BANKS banks of sky130 1rw1r 32x256 SRAM macros. An internal write pointer assigns each incoming patch the next address. One random-access read port with a pipelined bank select feeds the compute datapath. Sits between the patch I/O deserialiser and the kd-tree search / distance engines.

Parameters:
DATA_WIDTH, 11, bits per patch element
PATCH_SIZE, 5, elements per patch
NUM_BANKS, 2, SRAM banks; each bank holds BANK_DEPTH patches
BANK_DEPTH, 256, patches per bank; fixed by macro depth
MACRO_WIDTH, 32, macro data width; MACROS_PER_BANK = ceil(PATCH_SIZE*DATA_WIDTH/MACRO_WIDTH)
ADDR_WIDTH, $clog2(NUM_BANKS*BANK_DEPTH), global patch address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous: reset write pointer/count; SRAM contents untouched
wr_valid  in  1  write patch present
wr_ready  out  1  block accepts write (= !full)
wr_patch  in  PATCH_SIZE*DATA_WIDTH  patch to store, element 0 in LSBs
wr_count  out  ADDR_WIDTH+1  patches stored since reset/clear
full  out  1  wr_count == NUM_BANKS*BANK_DEPTH
rd_req  in  1  read request
rd_addr  in  ADDR_WIDTH  global patch address
rd_valid  out  1  rd_patch valid this cycle
rd_patch  out  PATCH_SIZE*DATA_WIDTH  read patch, same packing as wr_patch

Behaviour:
- Reset (async, rst_n=0): wr_count=0, full=0, wr_ready=1, rd_valid=0, rd_patch=0, pipeline registers cleared. No macro selected during reset.
- Address map: bank = addr / BANK_DEPTH; row = addr % BANK_DEPTH. Write uses macro port 0, read uses port 1.
- Packing: patch bits split LSB-first across MACROS_PER_BANK macros. Unused top bits are written as 0. No rotation on readback: rd_patch bits equal wr_patch bits exactly.
- Write: on wr_valid && wr_ready at clock edge, store at address wr_count, then wr_count += 1. Only the target bank's csb0/web0 are asserted (active low). When full, wr_ready=0 and wr_valid is ignored; no wrap-around.
- clear: wr_count <- 0 next cycle. A write in the same cycle as clear is dropped. clear has priority.
- Read latency is 2 cycles. Request at cycle N drives the macro csb1/addr1 for the selected bank only. Macro data appears at N+1. rd_patch/rd_valid are registered at N+2.
- The bank index is pipelined alongside the request. The output mux uses the delayed bank, never the live rd_addr.
- Fully pipelined: one read per cycle. rd_valid=0 in cycles with no request N-2. rd_patch holds its last value when rd_valid=0.
- Out of range: rd_addr >= NUM_BANKS*BANK_DEPTH (non-power-of-2 bank count) issues no macro access; returns rd_patch=0 with rd_valid=1 at N+2.
- Read/write collision: same address accepted in the same cycle returns the write data. The write patch and a hit flag are captured in a bypass register and muxed at N+2.
- Reading an address >= wr_count is legal and returns stale SRAM contents.
- Reset mid-read: in-flight requests are discarded; rd_valid=0 after release until a new request completes.

Optional Feature:
PATCH_PARITY_EN.
- Defined: one even-parity bit per element is stored in the unused macro MSBs (requires MACROS_PER_BANK*MACRO_WIDTH >= PATCH_SIZE*(DATA_WIDTH+1)). Adds output rd_parity_err [PATCH_SIZE-1:0], valid with rd_valid, reset 0. The collision bypass path always reports no error.
- Undefined: no parity bits (stored as 0), and the rd_parity_err port is absent.

Test Plan:
- Reset, then write 512 patches with element values = index: wr_count 0->512, full=1 and wr_ready=0 after the 512th. A 513th wr_valid leaves wr_count=512.
- Read addr 5, 255, 256, 511 back-to-back on consecutive cycles: rd_valid high for 4 consecutive cycles starting 2 cycles after the first request; data 5, 255, 256, 511 with correct bank per cycle.
- Write addr 10 with patch 55'h1234 while reading addr 10 in the same cycle: rd_patch=55'h1234 at N+2.
- After 300 writes, pulse clear with wr_valid=1: that write is dropped, wr_count=0. The next write lands at addr 0; addr 299 still reads old data.
- Assert rst_n=0 one cycle after rd_req: rd_valid stays 0, rd_patch=0, wr_count=0.
- PATCH_PARITY_EN: force a flipped bit in the bank-1 macro at row 3, then read addr 259: rd_parity_err flags that element only.
